// File: rtl/pipe_pkg.sv
// Shared defaults, forwarding-select encoding and scoreboard entry type for the
// pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned AW_DEF         = 4;
    localparam int unsigned NSRC_DEF       = 2;
    localparam int unsigned DEPTH_DEF      = 3;
    localparam int unsigned LOAD_STAGE_DEF = 2;
    localparam int unsigned BR_STAGE_DEF   = 2;

    // Register ids are zero-extended to this width inside the scoreboard.
    localparam int unsigned SB_AW_MAX = 8;

    // fwd_sel encoding: 0 = register file, k = result leaving stage k+1.
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                 valid;
        logic                 is_load;
        logic [SB_AW_MAX-1:0] dst_id;
    } sb_entry_t;

    function automatic int unsigned fwd_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-producer priority encoder for one source operand: returns the
// forwarding stage and whether the producer is a load still short of its data.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int unsigned FW         = fwd_w(DEPTH_DEF)
) (
    input  logic                  src_en,
    input  logic [SB_AW_MAX-1:0]  src_id,
    input  sb_entry_t [DEPTH:1]   sb,
    output logic [FW-1:0]         stage,
    output logic                  load_haz
);

    // Scan oldest to youngest so the youngest match is the one left standing;
    // a WB match resolves to the register file since it writes through.
    always_comb begin
        stage    = FW'(FWD_RF);
        load_haz = 1'b0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (src_en && sb[k].valid && (sb[k].dst_id == src_id)) begin
                stage    = (k < int'(DEPTH)) ? FW'(k) : FW'(FWD_RF);
                load_haz = sb[k].is_load && (k < int'(LOAD_STAGE));
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: destination scoreboard, forwarding select,
// load-use stall, branch/jump flush and memory freeze with event counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned NSRC       = NSRC_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
    parameter int unsigned BR_STAGE   = BR_STAGE_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          id_valid,
    input  logic [NSRC-1:0]               id_src_en,
    input  logic [NSRC*AW-1:0]            id_src_id,
    input  logic                          id_dst_en,
    input  logic [AW-1:0]                 id_dst_id,
    input  logic                          id_is_load,
    input  logic                          ex_jump,
    input  logic                          br_taken,
    input  logic                          mem_busy,
    output logic                          pc_write,
    output logic                          ifid_write,
    output logic                          idex_bubble,
    output logic                          flush_ifid,
    output logic                          kill_young,
    output logic [NSRC*fwd_w(DEPTH)-1:0]  fwd_sel,
    output logic [15:0]                   stall_cnt,
    output logic [15:0]                   flush_cnt
);

    localparam int unsigned FW = fwd_w(DEPTH);

    sb_entry_t [DEPTH:1]  sb_q, sb_d;
    logic [NSRC*FW-1:0]   fwd_q, fwd_d;
    logic [NSRC*FW-1:0]   match_k;
    logic [NSRC-1:0]      src_haz;
    logic                 load_use;
    logic [15:0]          stall_q, flush_q;

    for (genvar s = 0; s < int'(NSRC); s++) begin : g_match
        fwd_match #(
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .FW         (FW)
        ) u_fwd_match (
            .src_en   (id_valid & id_src_en[s]),
            .src_id   (SB_AW_MAX'(id_src_id[s*AW +: AW])),
            .sb       (sb_q),
            .stage    (match_k[s*FW +: FW]),
            .load_haz (src_haz[s])
        );
    end

    assign load_use = |src_haz;

    // Priority: freeze > branch > jump > load-use > advance. Reset forces all low.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        kill_young  = 1'b0;
        if (!RST && !mem_busy) begin
            if (br_taken) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b1;
                flush_ifid  = 1'b1;
                kill_young  = 1'b1;
            end else if (ex_jump) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_bubble = 1'b1;
                flush_ifid  = 1'b1;
            end else if (load_use) begin
                idex_bubble = 1'b1;
            end else begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
            end
        end
    end

    always_comb begin
        sb_d  = sb_q;
        fwd_d = fwd_q;
        if (!mem_busy) begin
            for (int k = int'(DEPTH); k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
                // Entries younger than the branch stage are wrong-path work.
                if (br_taken && ((k - 1) < int'(BR_STAGE))) begin
                    sb_d[k].valid = 1'b0;
                end
            end
            sb_d[1].valid   = id_valid & id_dst_en & ~idex_bubble & ~flush_ifid;
            sb_d[1].is_load = id_is_load;
            sb_d[1].dst_id  = SB_AW_MAX'(id_dst_id);
            fwd_d           = idex_bubble ? '0 : match_k;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sb_q    <= '0;
            fwd_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            sb_q  <= sb_d;
            fwd_q <= fwd_d;
            if (!pc_write && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush_ifid && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign fwd_sel   = fwd_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each row pushes its expected control
// vector and forwarding select, popped and compared as the DUT responds.
module tb_pipe_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        id_valid;
    logic [1:0]  id_src_en;
    logic [7:0]  id_src_id;
    logic        id_dst_en;
    logic [3:0]  id_dst_id;
    logic        id_is_load;
    logic        ex_jump;
    logic        br_taken;
    logic        mem_busy;
    logic        pc_write, ifid_write, idex_bubble, flush_ifid, kill_young;
    logic [3:0]  fwd_sel;
    logic [15:0] stall_cnt, flush_cnt;
    logic [4:0]  ctrl_vec;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .id_valid    (id_valid),
        .id_src_en   (id_src_en),
        .id_src_id   (id_src_id),
        .id_dst_en   (id_dst_en),
        .id_dst_id   (id_dst_id),
        .id_is_load  (id_is_load),
        .ex_jump     (ex_jump),
        .br_taken    (br_taken),
        .mem_busy    (mem_busy),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_bubble (idex_bubble),
        .flush_ifid  (flush_ifid),
        .kill_young  (kill_young),
        .fwd_sel     (fwd_sel),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign ctrl_vec = {pc_write, ifid_write, idex_bubble, flush_ifid, kill_young};

    // {pc_write, ifid_write, idex_bubble, flush_ifid, kill_young}
    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] LU   = 5'b00100;
    localparam logic [4:0] BR   = 5'b11111;
    localparam logic [4:0] JMP  = 5'b11110;
    localparam logic [4:0] FRZ  = 5'b00000;

    typedef struct packed {
        logic       v;
        logic [1:0] se;
        logic [3:0] s0;
        logic [3:0] s1;
        logic       de;
        logic [3:0] d;
        logic       ld;
        logic       jmp;
        logic       br;
        logic       busy;
        logic [4:0] ectrl;
        logic [3:0] efwd;
    } stim_t;

    typedef struct packed {
        logic [4:0] ctrl;
        logic [3:0] fwd;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_stall = '0;
    logic [15:0] exp_flush = '0;

    function automatic stim_t row(input logic v, input logic [1:0] se, input logic [3:0] s0,
                                  input logic [3:0] s1, input logic de, input logic [3:0] d,
                                  input logic ld, input logic jmp, input logic br,
                                  input logic busy, input logic [4:0] ectrl,
                                  input logic [3:0] efwd);
        stim_t r;
        r = '{v: v, se: se, s0: s0, s1: s1, de: de, d: d, ld: ld, jmp: jmp, br: br,
              busy: busy, ectrl: ectrl, efwd: efwd};
        return r;
    endfunction

    function automatic stim_t idle();
        return row(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 4'h0);
    endfunction

    task automatic drive(input stim_t r);
        id_valid   = r.v;
        id_src_en  = r.se;
        id_src_id  = {r.s1, r.s0};
        id_dst_en  = r.de;
        id_dst_id  = r.d;
        id_is_load = r.ld;
        ex_jump    = r.jmp;
        br_taken   = r.br;
        mem_busy   = r.busy;
        exp_q.push_back('{ctrl: r.ectrl, fwd: r.efwd});
    endtask

    task automatic model_counters(input logic [4:0] c);
        if (!c[4] && exp_stall != 16'hFFFF) exp_stall++;
        if (c[1] && exp_flush != 16'hFFFF) exp_flush++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(row(1'b1, 2'b01, 4'd1, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, FRZ, 4'h0));
        #2;
        begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (ctrl_vec !== e.ctrl)
                $display("FAIL reset_ctrl: got %b want %b", ctrl_vec, e.ctrl);
            else passes++;
            checks++;
            if (fwd_sel !== e.fwd)
                $display("FAIL reset_fwd: got %h want %h", fwd_sel, e.fwd);
            else passes++;
            checks++;
            if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush})
                $display("FAIL reset_cnt: got %0d/%0d want %0d/%0d",
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
            else passes++;
        end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_alu_forward();
        stim_t rows[$];
        exp_t  e;
        rows = '{idle(), idle(), idle(),
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd1, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b01, 4'd1, 4'd0, 1, 4'd4, 0, 0, 0, 0, NORM, 4'h1),
            row(1, 2'b10, 4'd1, 4'd4, 0, 4'd0, 0, 0, 0, 0, NORM, 4'h4),
            row(1, 2'b11, 4'd1, 4'd4, 0, 4'd0, 0, 0, 0, 0, NORM, 4'h8),
            idle(), idle(), idle(),
            // two writers of r3 back to back, reader must take the younger one
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd3, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b01, 4'd3, 4'd0, 1, 4'd3, 0, 0, 0, 0, NORM, 4'h1),
            row(1, 2'b11, 4'd3, 4'd3, 0, 4'd0, 0, 0, 0, 0, NORM, 4'h5)};
        foreach (rows[i]) begin
            drive(rows[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (ctrl_vec !== e.ctrl)
                $display("FAIL alu_ctrl row %0d: got %b want %b", i, ctrl_vec, e.ctrl);
            else passes++;
            model_counters(e.ctrl);
            @(posedge CLK);
            #1;
            checks++;
            if (fwd_sel !== e.fwd)
                $display("FAIL alu_fwd row %0d: got %h want %h", i, fwd_sel, e.fwd);
            else passes++;
            checks++;
            if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush})
                $display("FAIL alu_cnt row %0d: got %0d/%0d want %0d/%0d", i,
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
            else passes++;
            @(negedge CLK);
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        exp_t  e;
        rows = '{idle(), idle(), idle(),
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd2, 1, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, LU,   4'h0),
            row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, NORM, 4'h2)};
        foreach (rows[i]) begin
            drive(rows[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (ctrl_vec !== e.ctrl)
                $display("FAIL load_ctrl row %0d: got %b want %b", i, ctrl_vec, e.ctrl);
            else passes++;
            model_counters(e.ctrl);
            @(posedge CLK);
            #1;
            checks++;
            if (fwd_sel !== e.fwd)
                $display("FAIL load_fwd row %0d: got %h want %h", i, fwd_sel, e.fwd);
            else passes++;
            checks++;
            if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush})
                $display("FAIL load_cnt row %0d: got %0d/%0d want %0d/%0d", i,
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
            else passes++;
            @(negedge CLK);
        end
    endtask

    task automatic test_flush();
        stim_t rows[$];
        exp_t  e;
        rows = '{idle(), idle(), idle(),
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd5, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b01, 4'd5, 4'd0, 1, 4'd6, 0, 1, 1, 0, BR,   4'h0),
            row(1, 2'b11, 4'd5, 4'd6, 0, 4'd0, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd8, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b00, 4'd0, 4'd0, 1, 4'd9, 0, 1, 0, 0, JMP,  4'h0),
            row(1, 2'b11, 4'd8, 4'd9, 0, 4'd0, 0, 0, 0, 0, NORM, 4'h2)};
        foreach (rows[i]) begin
            drive(rows[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (ctrl_vec !== e.ctrl)
                $display("FAIL flush_ctrl row %0d: got %b want %b", i, ctrl_vec, e.ctrl);
            else passes++;
            model_counters(e.ctrl);
            @(posedge CLK);
            #1;
            checks++;
            if (fwd_sel !== e.fwd)
                $display("FAIL flush_fwd row %0d: got %h want %h", i, fwd_sel, e.fwd);
            else passes++;
            checks++;
            if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush})
                $display("FAIL flush_cnt row %0d: got %0d/%0d want %0d/%0d", i,
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
            else passes++;
            @(negedge CLK);
        end
    endtask

    task automatic test_mem_busy();
        stim_t rows[$];
        stim_t rd;
        exp_t  e;
        rd   = row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 1, FRZ, 4'h1);
        rows = '{idle(), idle(), idle(),
            row(1, 2'b00, 4'd0,  4'd0, 1, 4'd10, 0, 0, 0, 0, NORM, 4'h0),
            row(1, 2'b01, 4'd10, 4'd0, 1, 4'd2,  1, 0, 0, 0, NORM, 4'h1),
            rd, rd, rd, rd,
            row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, LU,   4'h0),
            row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, NORM, 4'h2)};
        foreach (rows[i]) begin
            drive(rows[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (ctrl_vec !== e.ctrl)
                $display("FAIL busy_ctrl row %0d: got %b want %b", i, ctrl_vec, e.ctrl);
            else passes++;
            model_counters(e.ctrl);
            @(posedge CLK);
            #1;
            checks++;
            if (fwd_sel !== e.fwd)
                $display("FAIL busy_fwd row %0d: got %h want %h", i, fwd_sel, e.fwd);
            else passes++;
            checks++;
            if ({stall_cnt, flush_cnt} !== {exp_stall, exp_flush})
                $display("FAIL busy_cnt row %0d: got %0d/%0d want %0d/%0d", i,
                         stall_cnt, flush_cnt, exp_stall, exp_flush);
            else passes++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        drive(idle());
        void'(exp_q.pop_front());
        model_counters(NORM);
        repeat (3) @(negedge CLK);
        drive(row(1, 2'b00, 4'd0, 4'd0, 1, 4'd2, 1, 0, 0, 0, NORM, 4'h0));
        void'(exp_q.pop_front());
        @(negedge CLK);
        drive(row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, LU, 4'h0));
        #2;
        e = exp_q.pop_front();
        checks++;
        if (ctrl_vec !== e.ctrl)
            $display("FAIL rststall_pre: got %b want %b", ctrl_vec, e.ctrl);
        else passes++;
        RST       = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
        #1;
        checks++;
        if (ctrl_vec !== FRZ)
            $display("FAIL rststall_ctrl: got %b want %b", ctrl_vec, FRZ);
        else passes++;
        checks++;
        if ({fwd_sel, stall_cnt, flush_cnt} !== {4'h0, exp_stall, exp_flush})
            $display("FAIL rststall_state: got %h %0d %0d want 0 0 0",
                     fwd_sel, stall_cnt, flush_cnt);
        else passes++;
        @(negedge CLK);
        RST = 1'b0;
        // Same reader still in ID: scoreboard is empty so it must simply advance.
        drive(row(1, 2'b01, 4'd2, 4'd0, 1, 4'd7, 0, 0, 0, 0, NORM, 4'h0));
        #2;
        e = exp_q.pop_front();
        checks++;
        if (ctrl_vec !== e.ctrl)
            $display("FAIL rststall_first: got %b want %b", ctrl_vec, e.ctrl);
        else passes++;
        model_counters(e.ctrl);
        @(posedge CLK);
        #1;
        checks++;
        if ({fwd_sel, stall_cnt, flush_cnt} !== {e.fwd, exp_stall, exp_flush})
            $display("FAIL rststall_after: got %h %0d %0d want %h %0d %0d",
                     fwd_sel, stall_cnt, flush_cnt, e.fwd, exp_stall, exp_flush);
        else passes++;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_flush();
        test_mem_busy();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4: register-id width (GPRs plus decoder-mapped special registers).
REQ-002 SHALL have parameter NSRC, default 2: source operands per instruction.
REQ-003 SHALL have parameter DEPTH, default 3: result stages after ID (1=EX, 2=MEM, 3=WB).
REQ-004 SHALL have parameter LOAD_STAGE, default 2: stage whose output first carries load data.
REQ-005 SHALL have parameter BR_STAGE, default 2: stage where branch outcome resolves.
REQ-006 SHALL have ports: CLK in 1, the single clock; RST in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: id_valid in 1, ID holds a real instruction; id_src_en in NSRC, per-source read enable; id_src_id in NSRC*AW, source ids.
REQ-008 SHALL have ports: id_dst_en in 1, ID writes a register; id_dst_id in AW; id_is_load in 1.
REQ-009 SHALL have ports: ex_jump in 1, jump in EX; br_taken in 1, taken branch in BR_STAGE; mem_busy in 1, memory not ready.
REQ-010 SHALL have ports: pc_write out 1; ifid_write out 1; idex_bubble out 1; flush_ifid out 1; kill_young out 1, squash stages 1..BR_STAGE-1.
REQ-011 SHALL have ports: fwd_sel out NSRC*clog2(DEPTH), registered; stall_cnt out 16; flush_cnt out 16.

Function
REQ-012 SHALL keep a scoreboard of DEPTH entries {valid, dst_id, is_load}; entry k tracks stage k.
REQ-013 Advance (no freeze) SHALL shift entry k into k+1, drop entry DEPTH, and load entry 1 from ID (valid = id_valid & id_dst_en & ~idex_bubble & ~flush).
REQ-014 Freeze: mem_busy=1 SHALL force pc_write=ifid_write=0, idex_bubble=flush_ifid=kill_young=0, and hold scoreboard and fwd_sel.
REQ-015 Per source s, match SHALL be the youngest valid entry k in 1..DEPTH-1 with dst_id==src_id[s] and src_en[s]=1; WB-stage matches need no forwarding (register file is write-through).
REQ-016 On advance, fwd_sel[s] SHALL register k of the match (consumer in EX takes stage k+1 result), else 0.
REQ-017 Load-use: match is_load with k<LOAD_STAGE SHALL stall: pc_write=ifid_write=0, idex_bubble=1, entry 1 loaded invalid.
REQ-018 br_taken (not frozen) SHALL assert flush_ifid, kill_young, idex_bubble, pc_write=1; entries 1..BR_STAGE-1 invalidated before shift.
REQ-019 ex_jump (not frozen, no br_taken) SHALL assert flush_ifid and idex_bubble, pc_write=1; entry 1 kept.
REQ-020 Priority SHALL be: mem_busy > br_taken > ex_jump > load-use stall > normal advance.
REQ-021 Normal advance SHALL drive pc_write=ifid_write=1, all else 0.
REQ-022 stall_cnt SHALL increment each non-reset cycle with pc_write=0; flush_cnt on each flush_ifid cycle; both saturate at 0xFFFF.
REQ-023 Hazard outputs SHALL be combinational from scoreboard and current inputs, zero-latency same cycle.

Reset
REQ-024 RST=1 SHALL asynchronously clear scoreboard valids, fwd_sel, stall_cnt, flush_cnt.
REQ-025 While RST=1, pc_write, ifid_write, idex_bubble, flush_ifid, kill_young SHALL be 0.
REQ-026 Reset mid-stall/flush SHALL discard pending hazards; first cycle after release is normal advance.

Structure
REQ-027 Shared package pipe_pkg SHALL hold the default parameter values, fwd_sel encoding (0=register file, k=stage k+1) and the scoreboard entry typedef.
REQ-028 Per-source youngest-match priority encoder SHALL be sub-module fwd_match, instantiated NSRC times.

Verification
REQ-029 ALU r1 then dependent ALU reading r1 -> no stall, fwd_sel=1 in EX.
REQ-030 Load r2 then immediate reader of r2 -> one cycle pc_write=0, idex_bubble=1, then fwd_sel=2; stall_cnt=1.
REQ-031 br_taken=1 with ex_jump=1 -> flush_ifid=kill_young=1, entry 1 invalid, flush_cnt +1.
REQ-032 mem_busy held 4 cycles during load-use -> all enables 0, state held, stall_cnt +4, stall resolves after release.
REQ-033 RST pulse mid-stall -> outputs 0 during reset, counters 0, normal advance first cycle after.
REQ-034 Two writers of r3 in EX and MEM, reader of r3 -> fwd_sel=1 (youngest wins).
